// File: rtl/nanosoc_ahb_trace_capture.sv
// rtl/nanosoc_ahb_trace_capture.sv - AHB bus/event trace capture with record FIFO
//   HCLK, HRESET          : clock, asynchronous active-high reset
//   HSEL_i .. HRESP_o     : observed AHB slave-side traffic (all inputs)
//   drq_i, dlast_i, irq_i : event lines snapshotted into event records
//   trc_en_i, filt_*_i    : capture enable and address filter
//   trc_valid_o/ready_i   : record stream handshake, trc_*_o carry the FIFO head
//   drop_cnt_o            : records dropped since the last overflow marker

module nanosoc_ahb_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             HCLK,
  input  logic             HRESET,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge HCLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  // Extra MSB distinguishes full from empty when the index bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

module nanosoc_ahb_trace_capture #(
  parameter int SYS_ADDR_W = 32,
  parameter int SYS_DATA_W = 32,
  parameter int DRQ_NUM    = 2,
  parameter int IRQ_NUM    = 4,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_W       = 32
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic                         HSEL_i,
  input  logic [SYS_ADDR_W-1:0]        HADDR_i,
  input  logic [1:0]                   HTRANS_i,
  input  logic [2:0]                   HSIZE_i,
  input  logic                         HWRITE_i,
  input  logic                         HREADY_i,
  input  logic [SYS_DATA_W-1:0]        HWDATA_i,
  input  logic [SYS_DATA_W-1:0]        HRDATA_o,
  input  logic                         HRESP_o,
  input  logic [DRQ_NUM-1:0]           drq_i,
  input  logic [DRQ_NUM-1:0]           dlast_i,
  input  logic [IRQ_NUM-1:0]           irq_i,
  input  logic                         trc_en_i,
  input  logic [SYS_ADDR_W-1:0]        filt_base_i,
  input  logic [SYS_ADDR_W-1:0]        filt_mask_i,
  output logic                         trc_valid_o,
  input  logic                         trc_ready_i,
  output logic [1:0]                   trc_kind_o,
  output logic [TS_W-1:0]              trc_ts_o,
  output logic [SYS_ADDR_W-1:0]        trc_addr_o,
  output logic [SYS_DATA_W-1:0]        trc_data_o,
  output logic [SYS_DATA_W/8-1:0]      trc_strb_o,
  output logic                         trc_write_o,
  output logic                         trc_resp_o,
  output logic [2*DRQ_NUM+IRQ_NUM-1:0] trc_evt_o,
  output logic [15:0]                  drop_cnt_o
);
  localparam int STRB_W = SYS_DATA_W / 8;
  localparam int LANE_W = $clog2(STRB_W);
  localparam int EVT_W  = 2*DRQ_NUM + IRQ_NUM;
  localparam int REC_W  = 2 + TS_W + SYS_ADDR_W + SYS_DATA_W + STRB_W + 2 + EVT_W;

  localparam logic [1:0] KIND_BUS = 2'd0;
  localparam logic [1:0] KIND_EVT = 2'd1;
  localparam logic [1:0] KIND_OVF = 2'd2;

  // Naturally aligned lane mask; sizes at or above the bus width light every lane.
  function automatic logic [STRB_W-1:0] lane_strb(input logic [2:0] size,
                                                  input logic [LANE_W-1:0] lo);
    logic [STRB_W-1:0] ones;
    logic [LANE_W-1:0] base;
    ones = '1;
    base = '0;
    if (int'(size) < LANE_W) begin
      ones = (STRB_W'(1) << (STRB_W'(1) << size)) - STRB_W'(1);
      base = lo & ~((LANE_W'(1) << size) - LANE_W'(1));
      ones = ones << base;
    end
    return ones;
  endfunction

  function automatic logic [SYS_DATA_W-1:0] lane_mask(input logic [STRB_W-1:0] s);
    logic [SYS_DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i < STRB_W; i++) m[i*8 +: 8] = {8{s[i]}};
    return m;
  endfunction

  logic [TS_W-1:0]       ts;
  logic                  dp_active;
  logic [SYS_ADDR_W-1:0] dp_addr;
  logic                  dp_write;
  logic [STRB_W-1:0]     dp_strb;
  logic [TS_W-1:0]       dp_ts;
  logic [EVT_W-1:0]      evt_last;
  logic [15:0]           drop_cnt;

  logic [EVT_W-1:0]      evt_snap;
  logic                  cap;
  logic                  full, empty, pop, space;
  logic                  bus_req, evt_req, ovf_wr, bus_wr, evt_wr, bus_drop, evt_drop;
  logic                  push;
  logic [15:0]           drop_base, drop_nxt;
  logic [16:0]           drop_sum;
  logic [REC_W-1:0]      rec, head;

  assign evt_snap = {irq_i, dlast_i, drq_i};
  assign cap = HREADY_i & HSEL_i & HTRANS_i[1] & trc_en_i &
               ((HADDR_i & filt_mask_i) == (filt_base_i & filt_mask_i));

  assign pop   = ~empty & trc_ready_i;
  // A full FIFO still accepts a write in the cycle its head is popped.
  assign space = ~full | pop;

  always_comb begin
    bus_req  = dp_active & HREADY_i;
    evt_req  = trc_en_i & (evt_snap != evt_last);
    ovf_wr   = (drop_cnt != 16'd0) & space;
    bus_wr   = bus_req & space & ~ovf_wr;
    bus_drop = bus_req & ~bus_wr;
    // An event beaten by another write keeps its request and retries.
    evt_wr   = evt_req & space & ~ovf_wr & ~bus_req;
    evt_drop = evt_req & ~space;
    push     = ovf_wr | bus_wr | evt_wr;

    drop_base = ovf_wr ? 16'd0 : drop_cnt;
    drop_sum  = {1'b0, drop_base} + 17'(bus_drop) + 17'(evt_drop);
    drop_nxt  = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

    rec = '0;
    if (ovf_wr) begin
      rec = {KIND_OVF, ts, SYS_ADDR_W'(0), SYS_DATA_W'(drop_cnt), STRB_W'(0), 2'b00, EVT_W'(0)};
    end else if (bus_wr) begin
      rec = {KIND_BUS, dp_ts, dp_addr,
             (dp_write ? HWDATA_i : HRDATA_o) & lane_mask(dp_strb),
             dp_strb, dp_write, HRESP_o, EVT_W'(0)};
    end else if (evt_wr) begin
      rec = {KIND_EVT, ts, SYS_ADDR_W'(0), SYS_DATA_W'(0), STRB_W'(0), 2'b00, evt_snap};
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ts        <= '0;
      dp_active <= 1'b0;
      dp_addr   <= '0;
      dp_write  <= 1'b0;
      dp_strb   <= '0;
      dp_ts     <= '0;
      evt_last  <= '0;
      drop_cnt  <= '0;
    end else begin
      ts <= ts + TS_W'(1);
      // The data-phase slot advances only on HREADY, so a pipelined
      // address phase can capture in the same cycle another completes.
      if (HREADY_i) begin
        dp_active <= cap;
        if (cap) begin
          dp_addr  <= HADDR_i;
          dp_write <= HWRITE_i;
          dp_strb  <= lane_strb(HSIZE_i, HADDR_i[LANE_W-1:0]);
          dp_ts    <= ts;
        end
      end
      if (evt_wr | evt_drop) evt_last <= evt_snap;
      drop_cnt <= drop_nxt;
    end
  end

  nanosoc_ahb_trace_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .push   (push),
    .wdata  (rec),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  // Gate the head so outputs read zero whenever nothing is queued.
  assign trc_valid_o = ~empty;
  assign {trc_kind_o, trc_ts_o, trc_addr_o, trc_data_o, trc_strb_o,
          trc_write_o, trc_resp_o, trc_evt_o} = empty ? '0 : head;
  assign drop_cnt_o = drop_cnt;
endmodule

// File: tb/tb_nanosoc_ahb_trace_capture.sv
// tb/tb_nanosoc_ahb_trace_capture.sv - scoreboard bench for nanosoc_ahb_trace_capture
module tb_nanosoc_ahb_trace_capture;
  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL_i;
  logic [31:0] HADDR_i;
  logic [1:0]  HTRANS_i;
  logic [2:0]  HSIZE_i;
  logic        HWRITE_i;
  logic        HREADY_i;
  logic [31:0] HWDATA_i;
  logic [31:0] HRDATA_o;
  logic        HRESP_o;
  logic [1:0]  drq_i;
  logic [1:0]  dlast_i;
  logic [3:0]  irq_i;
  logic        trc_en_i;
  logic [31:0] filt_base_i;
  logic [31:0] filt_mask_i;
  logic        trc_valid_o;
  logic        trc_ready_i;
  logic [1:0]  trc_kind_o;
  logic [31:0] trc_ts_o;
  logic [31:0] trc_addr_o;
  logic [31:0] trc_data_o;
  logic [3:0]  trc_strb_o;
  logic        trc_write_o;
  logic        trc_resp_o;
  logic [7:0]  trc_evt_o;
  logic [15:0] drop_cnt_o;

  nanosoc_ahb_trace_capture dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .HSEL_i      (HSEL_i),
    .HADDR_i     (HADDR_i),
    .HTRANS_i    (HTRANS_i),
    .HSIZE_i     (HSIZE_i),
    .HWRITE_i    (HWRITE_i),
    .HREADY_i    (HREADY_i),
    .HWDATA_i    (HWDATA_i),
    .HRDATA_o    (HRDATA_o),
    .HRESP_o     (HRESP_o),
    .drq_i       (drq_i),
    .dlast_i     (dlast_i),
    .irq_i       (irq_i),
    .trc_en_i    (trc_en_i),
    .filt_base_i (filt_base_i),
    .filt_mask_i (filt_mask_i),
    .trc_valid_o (trc_valid_o),
    .trc_ready_i (trc_ready_i),
    .trc_kind_o  (trc_kind_o),
    .trc_ts_o    (trc_ts_o),
    .trc_addr_o  (trc_addr_o),
    .trc_data_o  (trc_data_o),
    .trc_strb_o  (trc_strb_o),
    .trc_write_o (trc_write_o),
    .trc_resp_o  (trc_resp_o),
    .trc_evt_o   (trc_evt_o),
    .drop_cnt_o  (drop_cnt_o)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    logic [1:0]  kind;
    logic [31:0] ts;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic        write;
    logic        resp;
    logic [7:0]  evt;
    bit          chk_ts;
  } rec_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        write;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        resp;
    logic        en_a;
    logic        en_d;
    logic [3:0]  strb;
    logic [31:0] data;
  } vec_t;

  rec_t        exp_q[$];
  rec_t        mon_e;
  vec_t        vecs[9];
  int          tests = 0;
  int          fails = 0;
  logic [31:0] ts_m;

  // Reference timestamp: counts cycles since reset release.
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) ts_m <= '0;
    else        ts_m <= ts_m + 32'd1;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge HCLK) begin
    if (!HRESET && trc_valid_o && trc_ready_i) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_record: got kind %0d addr 0x%0h data 0x%0h, expected none",
                 trc_kind_o, trc_addr_o, trc_data_o);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rec_kind", 64'(trc_kind_o), 64'(mon_e.kind));
        chk("rec_addr", 64'(trc_addr_o), 64'(mon_e.addr));
        chk("rec_data", 64'(trc_data_o), 64'(mon_e.data));
        chk("rec_strb", 64'(trc_strb_o), 64'(mon_e.strb));
        chk("rec_write", 64'(trc_write_o), 64'(mon_e.write));
        chk("rec_resp", 64'(trc_resp_o), 64'(mon_e.resp));
        chk("rec_evt", 64'(trc_evt_o), 64'(mon_e.evt));
        if (mon_e.chk_ts) chk("rec_ts", 64'(trc_ts_o), 64'(mon_e.ts));
      end
    end
  end

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic push_bus(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic write, input logic resp);
    rec_t r;
    r = '{kind: 2'd0, ts: ts_m, addr: addr, data: data, strb: strb,
          write: write, resp: resp, evt: 8'h00, chk_ts: 1'b1};
    exp_q.push_back(r);
  endtask

  task automatic push_other(input logic [1:0] kind, input logic [31:0] data, input logic [7:0] evt);
    rec_t r;
    r = '{kind: kind, ts: 32'h0, addr: 32'h0, data: data, strb: 4'h0,
          write: 1'b0, resp: 1'b0, evt: evt, chk_ts: 1'b0};
    exp_q.push_back(r);
  endtask

  // One non-pipelined transfer: address phase, then data phase.
  task automatic xfer(input vec_t v, input bit expect_rec);
    HSEL_i = 1'b1; HTRANS_i = 2'b10; HADDR_i = v.addr; HSIZE_i = v.size;
    HWRITE_i = v.write; trc_en_i = v.en_a;
    if (expect_rec) push_bus(v.addr, v.data, v.strb, v.write, v.resp);
    step();
    HSEL_i = 1'b0; HTRANS_i = 2'b00; HWDATA_i = v.wd; HRDATA_o = v.rd;
    HRESP_o = v.resp; trc_en_i = v.en_d;
    step();
    trc_en_i = 1'b1; HRESP_o = 1'b0;
  endtask

  // Back-to-back pipelined word writes; only the first n_keep are expected.
  task automatic burst(input int n, input int n_keep, input logic [31:0] base);
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        HSEL_i = 1'b1; HTRANS_i = 2'b10; HADDR_i = base + 32'(4*i);
        HSIZE_i = 3'd2; HWRITE_i = 1'b1;
        if (i < n_keep) push_bus(base + 32'(4*i), 32'h10000000 + 32'(i), 4'hF, 1'b1, 1'b0);
      end else begin
        HSEL_i = 1'b0; HTRANS_i = 2'b00;
      end
      if (i > 0) HWDATA_i = 32'h10000000 + 32'(i-1);
      step();
    end
  endtask

  task automatic wait_drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    chk("drain_queue_left", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    HRESET = 1'b1; HSEL_i = 1'b0; HADDR_i = '0; HTRANS_i = '0; HSIZE_i = '0;
    HWRITE_i = 1'b0; HREADY_i = 1'b1; HWDATA_i = '0; HRDATA_o = '0; HRESP_o = 1'b0;
    drq_i = '0; dlast_i = '0; irq_i = '0; trc_en_i = 1'b1;
    filt_base_i = '0; filt_mask_i = '0; trc_ready_i = 1'b1;

    //          addr          sz   wr   wdata         rdata         rsp  en_a en_d strb  data
    vecs[0] = '{32'h40010004, 3'd2, 1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 1'b1, 1'b1, 4'hF, 32'hDEADBEEF};
    vecs[1] = '{32'h40010003, 3'd0, 1'b0, 32'h0,        32'h11223344, 1'b0, 1'b1, 1'b1, 4'h8, 32'h11000000};
    vecs[2] = '{32'h40010002, 3'd1, 1'b1, 32'hAABBCCDD, 32'h0,        1'b0, 1'b1, 1'b1, 4'hC, 32'hAABB0000};
    vecs[3] = '{32'h40010001, 3'd0, 1'b1, 32'hAABBCCDD, 32'h0,        1'b0, 1'b1, 1'b1, 4'h2, 32'h0000CC00};
    vecs[4] = '{32'h40010000, 3'd1, 1'b0, 32'h0,        32'h55667788, 1'b0, 1'b1, 1'b1, 4'h3, 32'h00007788};
    vecs[5] = '{32'h40010008, 3'd2, 1'b0, 32'h0,        32'hCAFEF00D, 1'b1, 1'b1, 1'b1, 4'hF, 32'hCAFEF00D};
    vecs[6] = '{32'h4001000C, 3'd3, 1'b1, 32'h01234567, 32'h0,        1'b0, 1'b1, 1'b1, 4'hF, 32'h01234567};
    vecs[7] = '{32'h40010010, 3'd2, 1'b1, 32'h77777777, 32'h0,        1'b0, 1'b0, 1'b1, 4'hF, 32'h77777777};
    vecs[8] = '{32'h40010014, 3'd2, 1'b0, 32'h0,        32'h88888888, 1'b0, 1'b1, 1'b0, 4'hF, 32'h88888888};

    #3;
    chk("rst_valid", 64'(trc_valid_o), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    chk("rst_kind", 64'(trc_kind_o), 64'd0);
    chk("rst_data", 64'(trc_data_o), 64'd0);
    step(); step();
    HRESET = 1'b0;
    step();

    foreach (vecs[i]) xfer(vecs[i], vecs[i].en_a);
    wait_drain(50);

    // Address filter: miss is silent, hit is recorded.
    filt_base_i = 32'h40020000; filt_mask_i = 32'hFFFF0000;
    xfer('{32'h40010000, 3'd2, 1'b1, 32'h12345678, 32'h0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h12345678}, 1'b0);
    xfer('{32'h40020010, 3'd2, 1'b1, 32'h9ABCDEF0, 32'h0, 1'b0, 1'b1, 1'b1, 4'hF, 32'h9ABCDEF0}, 1'b1);
    wait_drain(50);
    chk("filter_drop_cnt", 64'(drop_cnt_o), 64'd0);
    filt_base_i = '0; filt_mask_i = '0;

    // Interrupt edge coinciding with a completing data phase.
    HSEL_i = 1'b1; HTRANS_i = 2'b10; HADDR_i = 32'h40010020; HSIZE_i = 3'd2; HWRITE_i = 1'b1;
    push_bus(32'h40010020, 32'h0BADF00D, 4'hF, 1'b1, 1'b0);
    step();
    HSEL_i = 1'b0; HTRANS_i = 2'b00; HWDATA_i = 32'h0BADF00D; irq_i = 4'b0001;
    push_other(2'd1, 32'h0, 8'h10);
    repeat (4) step();
    irq_i = 4'b0000;
    push_other(2'd1, 32'h0, 8'h00);
    wait_drain(50);

    // Overflow: 20 writes into a stalled 16-entry FIFO.
    trc_ready_i = 1'b0;
    burst(20, 16, 32'h40030000);
    step();
    chk("ovf_drop_cnt", 64'(drop_cnt_o), 64'd4);
    chk("ovf_valid_held", 64'(trc_valid_o), 64'd1);
    push_other(2'd2, 32'd4, 8'h00);
    trc_ready_i = 1'b1;
    wait_drain(100);
    chk("ovf_drop_cleared", 64'(drop_cnt_o), 64'd0);

    // Reset with records queued discards them.
    trc_ready_i = 1'b0;
    burst(5, 0, 32'h40040000);
    step();
    chk("pre_rst_valid", 64'(trc_valid_o), 64'd1);
    #2;
    HRESET = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(trc_valid_o), 64'd0);
    chk("mid_rst_addr", 64'(trc_addr_o), 64'd0);
    chk("mid_rst_drop_cnt", 64'(drop_cnt_o), 64'd0);
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESET = 1'b0;
    trc_ready_i = 1'b1;
    repeat (10) step();
    chk("post_rst_idle", 64'(trc_valid_o), 64'd0);
    xfer(vecs[0], 1'b1);
    wait_drain(50);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/nanosoc_ahb_trace_capture.md
NANOSOC_AHB_TRACE_CAPTURE -- requirements
Module: nanosoc_ahb_trace_capture

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- SYS_ADDR_W, 32, AHB address width.
- SYS_DATA_W, 32, AHB data width; legal values 32 or 64.
- DRQ_NUM, 2, number of DMA request/last channel pairs.
- IRQ_NUM, 4, interrupt lines monitored.
- FIFO_DEPTH, 16, record FIFO entries; power of 2, minimum 4.
- TS_W, 32, timestamp width.
REQ-002 Ports (name, direction, width, meaning), one per line:
- HCLK, in, 1, clock.
- HRESET, in, 1, reset.
- HSEL_i, in, 1, slave select.
- HADDR_i, in, SYS_ADDR_W, address.
- HTRANS_i, in, 2, transfer type.
- HSIZE_i, in, 3, transfer size.
- HWRITE_i, in, 1, write.
- HREADY_i, in, 1, bus ready.
- HWDATA_i, in, SYS_DATA_W, write data.
- HRDATA_o, in, SYS_DATA_W, observed read data.
- HRESP_o, in, 1, observed response.
- drq_i, in, DRQ_NUM, DMA requests.
- dlast_i, in, DRQ_NUM, DMA last.
- irq_i, in, IRQ_NUM, interrupts.
- trc_en_i, in, 1, capture enable.
- filt_base_i, in, SYS_ADDR_W, filter base.
- filt_mask_i, in, SYS_ADDR_W, filter mask.
- trc_valid_o, out, 1, record valid.
- trc_ready_i, in, 1, record accepted.
- trc_kind_o, out, 2, record kind (0 = bus, 1 = event, 2 = overflow).
- trc_ts_o, out, TS_W, timestamp.
- trc_addr_o, out, SYS_ADDR_W, address.
- trc_data_o, out, SYS_DATA_W, data or drop count.
- trc_strb_o, out, SYS_DATA_W/8, byte lanes.
- trc_write_o, out, 1, write flag.
- trc_resp_o, out, 1, error response.
- trc_evt_o, out, 2*DRQ_NUM+IRQ_NUM, {irq, dlast, drq} snapshot.
- drop_cnt_o, out, 16, pending drop count.
REQ-003 One clock (HCLK); reset HRESET is asynchronous and active-high.

Function
REQ-004 Timestamp counter: TS_W bits; increments every cycle; wraps from all-ones to 0.
REQ-005 Address-phase capture when HREADY_i & HSEL_i & HTRANS_i[1] & trc_en_i & ((HADDR_i & filt_mask_i) == (filt_base_i & filt_mask_i)): register address, write flag, strobe, timestamp.
REQ-006 Strobe: lanes derived from HSIZE_i and the low address bits, covering 1, 2, 4 (and 8 when SYS_DATA_W = 64) bytes, naturally aligned; an HSIZE_i larger than the bus width sets all lanes.
REQ-007 Data phase completes on the first cycle with HREADY_i = 1 after capture.
- Bus record (kind 0) formed with HWDATA_i for writes, HRDATA_o for reads, and trc_resp_o = HRESP_o.
- Data lanes outside the strobe are zero.
- trc_en_i has no effect on a transfer already in data phase.
REQ-008 Event snapshot S = {irq_i, dlast_i, drq_i}; register L holds the last logged snapshot.
- Event record (kind 1) is requested whenever S != L and trc_en_i = 1.
- Carries S; addr, data, strb are zero.
- L <= S when the event record is written or dropped.
- Changes while waiting are coalesced into the newest S.
REQ-009 FIFO: FIFO_DEPTH entries, at most one write per cycle. Write priority: overflow marker > bus record > event record.
REQ-010 Overflow marker (kind 2) is written when drop_cnt_o != 0 and the FIFO is not full.
- Carries trc_data_o = zero-extended drop count; drop_cnt_o clears in the same cycle.
- Drops occurring that cycle count from 0.
REQ-011 Drops:
- A bus record that finds the FIFO full, or loses arbitration, is dropped.
- An event record that finds the FIFO full is dropped.
- Each drop increments drop_cnt_o, which saturates at 0xFFFF.
- An event that loses arbitration to a non-full write is not dropped; it retries next cycle.
REQ-012 Output handshake:
- trc_valid_o = FIFO not empty, with head fields on the outputs.
- Pop on trc_valid_o & trc_ready_i.
- Outputs are stable while trc_valid_o & !trc_ready_i.
- Simultaneous push and pop when full is permitted only if the pop frees the slot; full is evaluated before the pop.
REQ-013 Latency: a record written at edge N appears on trc_valid_o after edge N when the FIFO was empty (no bypass path).
REQ-014 Pointers: log2(FIFO_DEPTH)+1 bits, with wrap handled by the MSB.

Reset
REQ-015 HRESET = 1 forces, asynchronously:
- trc_valid_o = 0; all trc_*_o outputs 0; drop_cnt_o = 0.
- FIFO empty; timestamp 0; L = 0; no transfer in data phase.
REQ-016 Reset mid-transfer or mid-drain discards all captured state; no partial record is emitted after release.

Verification
REQ-017 Word write 0xDEADBEEF to 0x40010004, filter mask 0, trc_ready_i = 1 -> one kind-0 record: addr 0x40010004, strb 0xF, write 1, data 0xDEADBEEF.
REQ-018 Byte read at 0x40010003 returning HRDATA_o 0x11223344 -> strb 0x8, data 0x11000000, write 0.
REQ-019 trc_ready_i = 0, 20 back-to-back writes, FIFO_DEPTH 16 -> 16 records held, drop_cnt_o = 4; after draining one record -> an overflow record with data 4 follows.
REQ-020 irq_i 0000 -> 0001 in the same cycle a bus data phase completes -> bus record first, then an event record with irq field 0001.
REQ-021 Filter base 0x40020000, mask 0xFFFF0000, access to 0x40010000 -> no record, drop_cnt_o unchanged.
REQ-022 HRESET pulsed with 5 records queued -> trc_valid_o = 0 immediately; no records after release until new activity.
